// File: rtl/mem_req_responder.sv
// Memory-side responder: serves one read or write request at a time from a local word RAM,
// answering after a fixed latency. A host backdoor port preloads and dumps the RAM.
module mem_req_responder #(
    parameter int          ADDR_WID  = 12,
    parameter int          DATA_WID  = 32,
    parameter int          LATENCY   = 4,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic [63:0]         read_size,
    input  logic                finish_read,
    output logic [63:0]         read_ready,
    output logic [DATA_WID-1:0] read_data,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [DATA_WID-1:0] write_data,
    output logic [63:0]         write_ready,
    input  logic                host_we,
    input  logic [ADDR_WID-1:0] host_addr,
    input  logic [DATA_WID-1:0] host_wdata,
    output logic [DATA_WID-1:0] host_rdata,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic                protocol_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;
    localparam int         DEPTH      = 2 ** ADDR_WID;
    localparam logic [7:0] TIMER_INIT = 8'(LATENCY - 1);

    logic [DATA_WID-1:0] mem [0:DEPTH-1];

    logic [1:0]          state_reg;
    logic [7:0]          timer_reg;
    logic [ADDR_WID-1:0] idx_reg;
    logic                hit_reg;
    logic [DATA_WID-1:0] wdata_reg;

    // Byte offsets from the window base; the top bits must be zero for the word to exist.
    logic [63:0]         rd_off;
    logic [63:0]         wr_off;
    logic [ADDR_WID-1:0] rd_idx;
    logic [ADDR_WID-1:0] wr_idx;
    logic                rd_ok;
    logic                wr_ok;
    logic                wr_commit;
    logic                unused_ok;

    assign rd_off = read_addr - BASE_ADDR;
    assign wr_off = write_addr - BASE_ADDR;
    assign rd_idx = rd_off[ADDR_WID+1:2];
    assign wr_idx = wr_off[ADDR_WID+1:2];
    assign rd_ok  = (read_addr >= BASE_ADDR) && (read_addr[1:0] == 2'b00)
                    && (rd_off[63:ADDR_WID+2] == '0);
    assign wr_ok  = (write_addr >= BASE_ADDR) && (write_addr[1:0] == 2'b00)
                    && (wr_off[63:ADDR_WID+2] == '0);

    assign wr_commit = (state_reg == WR_WAIT) && (timer_reg == 8'd0) && hit_reg;

    // read_size and finish_read are informational only.
    assign unused_ok = ^{read_size, finish_read, rd_off[1:0], wr_off[1:0]};

    // RAM keeps its contents across reset; the responder write is last so it wins a collision.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
        if (wr_commit) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            idx_reg      <= '0;
            hit_reg      <= 1'b0;
            wdata_reg    <= '0;
            read_ready   <= '0;
            write_ready  <= '0;
            read_data    <= '0;
            host_rdata   <= '0;
            rd_count     <= '0;
            wr_count     <= '0;
            protocol_err <= 1'b0;
        end else begin
            read_ready  <= '0;
            write_ready <= '0;
            host_rdata  <= mem[host_addr];
            case (state_reg)
                IDLE: begin
                    if (read_enable) begin
                        state_reg <= RD_WAIT;
                        timer_reg <= TIMER_INIT;
                        idx_reg   <= rd_idx;
                        hit_reg   <= rd_ok;
                        if (rd_count != 32'hFFFF_FFFF) begin
                            rd_count <= rd_count + 32'd1;
                        end
                        if (write_enable || !rd_ok) begin
                            protocol_err <= 1'b1;
                        end
                    end else if (write_enable) begin
                        state_reg <= WR_WAIT;
                        timer_reg <= TIMER_INIT;
                        idx_reg   <= wr_idx;
                        hit_reg   <= wr_ok;
                        wdata_reg <= write_data;
                        if (wr_count != 32'hFFFF_FFFF) begin
                            wr_count <= wr_count + 32'd1;
                        end
                        if (!wr_ok) begin
                            protocol_err <= 1'b1;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (read_enable || write_enable) begin
                        protocol_err <= 1'b1;
                    end
                    if (timer_reg == 8'd0) begin
                        state_reg <= IDLE;
                        if (state_reg == RD_WAIT) begin
                            read_ready <= 64'd1;
                            read_data  <= hit_reg ? mem[idx_reg] : '0;
                        end else begin
                            write_ready <= 64'd1;
                        end
                    end else begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
